seg7_encoder: RTL and testbench
===============================

SEG7_ENCODER -- requirements
Module: seg7_encoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a pattern is accepted; legal range 1..255.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: i_seg  input  7  observed seven-segment pattern, active low, bit 0 = top segment, clockwise to bit 5, bit 6 = middle.
REQ-005 Port: o_hex  output  4  recovered hex digit of the accepted pattern.
REQ-006 Port: o_blank  output  1  accepted pattern was all segments off (7'h7F).
REQ-007 Port: o_err  output  1  accepted pattern matches no hex glyph and is not blank.
REQ-008 Port: o_valid  output  1  o_hex/o_blank/o_err hold a new accepted pattern.
REQ-009 Port: i_ready  input  1  consumer accepts the output when high with o_valid.

Function
REQ-010 i_seg SHALL be registered into seg_q every cycle; all decode and compare logic SHALL use seg_q only.
REQ-011 An 8-bit stability counter SHALL clear when i_seg != seg_q, otherwise increment, saturating at STABLE_CYCLES.
REQ-012 Glyph map (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-013 The FSM SHALL have two states: SETTLE (reset state, o_valid=0) and PRESENT (o_valid=1).
REQ-014 SETTLE->PRESENT when counter == STABLE_CYCLES and seg_q != last_reported; on that edge seg_q SHALL be captured and o_hex/o_blank/o_err loaded from it.
REQ-015 Decode on capture: glyph match -> o_hex=digit, o_blank=0, o_err=0; 7'h7F -> o_hex=0, o_blank=1, o_err=0; other -> o_hex=0, o_blank=0, o_err=1.
REQ-016 A pattern held from cycle 0 on i_seg SHALL produce o_valid first high in cycle STABLE_CYCLES+2.
REQ-017 In PRESENT, o_valid, o_hex, o_blank, o_err SHALL remain stable until the cycle where i_ready=1.
REQ-018 On o_valid && i_ready, last_reported SHALL load the captured pattern, counter SHALL clear and FSM SHALL return to SETTLE; o_valid low the next cycle.
REQ-019 i_seg changes while in PRESENT SHALL not alter outputs; sampling and counting continue, so a pattern stable during PRESENT SHALL be presented no earlier than one cycle after the handshake.
REQ-020 A pattern equal to last_reported SHALL never be presented again, regardless of stability duration.
REQ-021 A glitch of any length < STABLE_CYCLES+1 samples SHALL produce no output.

Reset
REQ-022 While rst=1 at a rising edge: FSM=SETTLE, seg_q=7'h7F, last_reported=7'h7F, counter=0, o_valid=0, o_hex=0, o_blank=0, o_err=0.
REQ-023 rst asserted in PRESENT SHALL drop o_valid on the following cycle and discard the captured pattern without updating last_reported beyond its reset value.
REQ-024 A blank display after reset SHALL not be reported.

Configuration
REQ-025 Macro SEG7_ENCODER_ERR_CNT_EN: when defined, output o_err_cnt (8 bits) SHALL count handshakes completed with o_err=1, saturating at 255, reset to 0 by rst.
REQ-026 Without SEG7_ENCODER_ERR_CNT_EN, o_err_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-027 Reset, then i_seg=7'h24 held from cycle 0, i_ready=1, STABLE_CYCLES=4 -> o_valid high only in cycle 6, o_hex=2, o_blank=0, o_err=0.
REQ-028 i_seg=7'h30 held, i_ready=0 for 10 cycles then 1; i_seg changed to 7'h19 during the wait -> o_hex=3 stable throughout, after handshake o_hex=4 presented.
REQ-029 i_seg=7'h19 for 3 cycles then back to 7'h7F -> o_valid never asserts.
REQ-030 i_seg=7'h55 held -> one transfer with o_err=1, o_hex=0; with SEG7_ENCODER_ERR_CNT_EN, o_err_cnt=1 after handshake.
REQ-031 i_seg=7'h79 accepted, then held 50 more cycles -> no second o_valid; then 7'h7F held -> one transfer with o_blank=1.
REQ-032 rst pulsed during PRESENT with i_seg=7'h12 held -> o_valid low next cycle, then 7'h12 re-presented STABLE_CYCLES+2 cycles after rst releases.

Source files
------------

// File: rtl/seg7_encoder.sv
// Seven-segment pattern decoder: debounces an observed active-low segment bus and
// reports each newly stable glyph once over a valid/ready handshake.
// Optional SEG7_ENCODER_ERR_CNT_EN adds o_err_cnt, a saturating count of error transfers.

package seg7_encoder_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned HEX_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [HEX_W-1:0] hex;
    logic             blank;
    logic             err;
  } seg7_dec_t;

  // Active-low glyph table; anything that is neither a glyph nor blank is an error.
  function automatic seg7_dec_t seg7_decode(input logic [SEG_W-1:0] seg);
    seg7_dec_t d;
    d = '0;
    case (seg)
      7'h40:   d.hex = 4'h0;
      7'h79:   d.hex = 4'h1;
      7'h24:   d.hex = 4'h2;
      7'h30:   d.hex = 4'h3;
      7'h19:   d.hex = 4'h4;
      7'h12:   d.hex = 4'h5;
      7'h02:   d.hex = 4'h6;
      7'h78:   d.hex = 4'h7;
      7'h00:   d.hex = 4'h8;
      7'h18:   d.hex = 4'h9;
      7'h08:   d.hex = 4'hA;
      7'h03:   d.hex = 4'hB;
      7'h46:   d.hex = 4'hC;
      7'h21:   d.hex = 4'hD;
      7'h06:   d.hex = 4'hE;
      7'h0E:   d.hex = 4'hF;
      7'h7F:   d.blank = 1'b1;
      default: d.err = 1'b1;
    endcase
    return d;
  endfunction

endpackage

module seg7_encoder
  import seg7_encoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] i_seg,
  input  logic             i_ready,
  output logic [HEX_W-1:0] o_hex,
  output logic             o_blank,
  output logic             o_err,
  output logic             o_valid
`ifdef SEG7_ENCODER_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] o_err_cnt
`endif
);

  localparam logic [CNT_W-1:0] STABLE_Q = CNT_W'(STABLE_CYCLES);
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    SETTLE  = 1'b0,
    PRESENT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SEG_W-1:0] seg_q;
  logic [SEG_W-1:0] cap_q;
  logic [SEG_W-1:0] last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             capture;
  logic             handshake;
  seg7_dec_t        dec;

  assign dec = seg7_decode(seg_q);

  // Next-state: accept a fresh stable pattern, release it on handshake.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      SETTLE: begin
        if ((cnt_q == STABLE_Q) && (seg_q != last_q)) begin
          state_d = PRESENT;
          capture = 1'b1;
        end
      end
      PRESENT: begin
        if (i_ready) begin
          state_d   = SETTLE;
          handshake = 1'b1;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SETTLE;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      o_valid <= (state_d == PRESENT);
    end
  end

  // Input sampling and stability counting run in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      cnt_q <= '0;
    end else begin
      seg_q <= i_seg;
      if (handshake || (i_seg != seg_q)) begin
        cnt_q <= '0;
      end else if (cnt_q < STABLE_Q) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q   <= SEG_BLANK;
      last_q  <= SEG_BLANK;
      o_hex   <= '0;
      o_blank <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      if (capture) begin
        cap_q   <= seg_q;
        o_hex   <= dec.hex;
        o_blank <= dec.blank;
        o_err   <= dec.err;
      end
      if (handshake) begin
        last_q <= cap_q;
      end
    end
  end

`ifdef SEG7_ENCODER_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err_cnt <= '0;
    end else if (handshake && o_err && (o_err_cnt != {CNT_W{1'b1}})) begin
      o_err_cnt <= o_err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seg7_encoder.sv
// Directed bench for seg7_encoder: expected transfers are queued as stimulus is
// driven and checked against the outputs on every cycle o_valid is high.

module tb_seg7_encoder;

  typedef struct packed {
    logic [3:0] hex;
    logic       blank;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [6:0] i_seg;
  logic       i_ready;
  logic [3:0] o_hex;
  logic       o_blank;
  logic       o_err;
  logic       o_valid;
`ifdef SEG7_ENCODER_ERR_CNT_EN
  logic [7:0] o_err_cnt;
`endif

  seg7_encoder #(.STABLE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_seg    (i_seg),
    .i_ready  (i_ready),
    .o_hex    (o_hex),
    .o_blank  (o_blank),
    .o_err    (o_err),
    .o_valid  (o_valid)
`ifdef SEG7_ENCODER_ERR_CNT_EN
    ,
    .o_err_cnt(o_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  int   cyc_n;
  int   nvalid;
  int   nxfer;
  int   first_valid;
  logic [6:0] glyph_tab [16];

  function automatic exp_t mk(input logic [3:0] hex, input logic blank, input logic err);
    exp_t e;
    e.hex   = hex;
    e.blank = blank;
    e.err   = err;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: scoreboard check at negedge, then advance past the rising edge.
  task automatic cyc();
    exp_t got;
    @(negedge clk);
    if (o_valid === 1'b1) begin
      nvalid++;
      if (first_valid < 0) first_valid = cyc_n;
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_valid: observed valid at cycle %0d, expected none", cyc_n);
      end
      if (exp_q.size() > 0) begin
        got = {o_hex, o_blank, o_err};
        vectors++;
        assert (got === exp_q[0]) else begin
          miscompares++;
          $error("FAIL transfer: observed hex/blank/err %0h, expected %0h", got, exp_q[0]);
        end
        if (i_ready === 1'b1) begin
          void'(exp_q.pop_front());
          nxfer++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic start_seg();
    cyc_n       = 0;
    nvalid      = 0;
    nxfer       = 0;
    first_valid = -1;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int start;
    start = nvalid;
    for (int i = 0; i < max_cyc; i++) begin
      if (nvalid == start) cyc();
    end
    check(tag, 32'(nvalid != start), 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    start_seg();

    // Reset with a live pattern on the bus.
    rst     = 1'b1;
    i_seg   = 7'h55;
    i_ready = 1'b0;
    repeat (3) cyc();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_hex",   32'(o_hex),   32'd0);
    check("rst_blank", 32'(o_blank), 32'd0);
    check("rst_err",   32'(o_err),   32'd0);
`ifdef SEG7_ENCODER_ERR_CNT_EN
    check("rst_err_cnt", 32'(o_err_cnt), 32'd0);
`endif

    // Digit 2 held from cycle 0: single transfer in cycle 6.
    rst     = 1'b0;
    i_seg   = 7'h24;
    i_ready = 1'b1;
    exp_q.push_back(mk(4'h2, 1'b0, 1'b0));
    start_seg();
    repeat (12) cyc();
    check("d2_first_valid", 32'(first_valid), 32'd6);
    check("d2_nvalid",      32'(nvalid),      32'd1);
    check("d2_nxfer",       32'(nxfer),       32'd1);

    // Digit 3 stalled 10 cycles; bus moves to 4 during the stall.
    i_ready = 1'b0;
    i_seg   = 7'h30;
    exp_q.push_back(mk(4'h3, 1'b0, 1'b0));
    start_seg();
    wait_valid("d3_valid_timeout", 20);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        i_seg = 7'h19;
        exp_q.push_back(mk(4'h4, 1'b0, 1'b0));
      end
      cyc();
    end
    check("d3_held_valid", 32'(nvalid), 32'd11);
    i_ready = 1'b1;
    repeat (15) cyc();
    check("d3_d4_nxfer", 32'(nxfer), 32'd2);
    check("d3_d4_queue", 32'(exp_q.size()), 32'd0);

    // Glitch of 4 samples is ignored; 5 samples is accepted, then blank follows.
    rst = 1'b1;
    cyc();
    rst   = 1'b0;
    i_seg = 7'h19;
    start_seg();
    repeat (4) cyc();
    i_seg = 7'h7F;
    repeat (10) cyc();
    check("glitch_nvalid", 32'(nvalid), 32'd0);
    i_seg = 7'h19;
    exp_q.push_back(mk(4'h4, 1'b0, 1'b0));
    exp_q.push_back(mk(4'h0, 1'b1, 1'b0));
    start_seg();
    repeat (5) cyc();
    i_seg = 7'h7F;
    repeat (10) cyc();
    check("edge5_first_valid", 32'(first_valid), 32'd6);
    check("edge5_nxfer",       32'(nxfer),       32'd2);

    // Non-glyph pattern reports an error.
    i_seg = 7'h55;
    exp_q.push_back(mk(4'h0, 1'b0, 1'b1));
    start_seg();
    repeat (12) cyc();
    check("err_nxfer", 32'(nxfer), 32'd1);
`ifdef SEG7_ENCODER_ERR_CNT_EN
    check("err_cnt_one", 32'(o_err_cnt), 32'd1);
`endif

    // Every glyph in turn.
    start_seg();
    for (int g = 0; g < 16; g++) begin
      i_seg = glyph_tab[g];
      exp_q.push_back(mk(4'(g), 1'b0, 1'b0));
      repeat (9) cyc();
    end
    check("glyphs_nxfer", 32'(nxfer), 32'd16);

    // Digit 1 accepted once despite a long hold, then blank reported.
    i_seg = 7'h79;
    exp_q.push_back(mk(4'h1, 1'b0, 1'b0));
    start_seg();
    repeat (60) cyc();
    check("d1_nvalid", 32'(nvalid), 32'd1);
    i_seg = 7'h7F;
    exp_q.push_back(mk(4'h0, 1'b1, 1'b0));
    start_seg();
    repeat (12) cyc();
    check("blank_nxfer", 32'(nxfer), 32'd1);

    // Reset during PRESENT discards the capture; digit 5 is re-presented.
    i_ready = 1'b0;
    i_seg   = 7'h12;
    exp_q.push_back(mk(4'h5, 1'b0, 1'b0));
    start_seg();
    wait_valid("d5_valid_timeout", 20);
    rst = 1'b1;
    cyc();
    rst     = 1'b0;
    i_ready = 1'b1;
    check("rst_drop_valid", 32'(o_valid), 32'd0);
`ifdef SEG7_ENCODER_ERR_CNT_EN
    check("rst_err_cnt_clear", 32'(o_err_cnt), 32'd0);
`endif
    start_seg();
    repeat (12) cyc();
    check("d5_first_valid", 32'(first_valid), 32'd6);
    check("d5_nxfer",       32'(nxfer),       32'd1);
    check("final_queue",    32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
